// File: rtl/dtw_mem_pkg.sv
// rtl/dtw_mem_pkg.sv - shared memory geometry and arbiter state type
package dtw_mem_pkg;

  localparam int AW        = 10;
  localparam int DW        = 32;
  localparam int MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter with
// round-robin selection, lockable bursts and a bounded hold time
module mem_arbiter
  import dtw_mem_pkg::*;
#(
  parameter int AW       = dtw_mem_pkg::AW,
  parameter int DW       = dtw_mem_pkg::DW,
  parameter int MAX_HOLD = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,

  input  logic          i_a_req,
  input  logic          i_a_lock,
  input  logic          i_a_wr,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_gnt,
  output logic          o_a_rvalid,
  output logic [DW-1:0] o_a_rdata,

  input  logic          i_b_req,
  input  logic          i_b_lock,
  input  logic          i_b_wr,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_gnt,
  output logic          o_b_rvalid,
  output logic [DW-1:0] o_b_rdata,

  output logic          o_mem_CS,
  output logic          o_mem_WR,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  input  logic [DW-1:0] i_mem_data
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_t    state, state_next;
  logic          rr_b, rr_b_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic          hold_expired;
  logic          gnt_a, gnt_b;
  logic          a_rvalid, b_rvalid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      rr_b     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_b     <= rr_b_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // hold_cnt is zero on the first owned cycle, so MAX_HOLD-1 marks the last one
  assign hold_expired = (hold_cnt == HW'(MAX_HOLD - 1));

  always_comb begin
    state_next    = state;
    rr_b_next     = rr_b;
    hold_cnt_next = '0;
    if (gnt_a) begin
      rr_b_next = 1'b1;
    end else if (gnt_b) begin
      rr_b_next = 1'b0;
    end
    case (state)
      IDLE: begin
        if (gnt_a && i_a_lock) begin
          state_next = OWN_A;
        end else if (gnt_b && i_b_lock) begin
          state_next = OWN_B;
        end
      end
      OWN_A: begin
        if (!i_a_lock) begin
          state_next = IDLE;
        end else if (hold_expired) begin
          state_next = IDLE;
          rr_b_next  = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!i_b_lock) begin
          state_next = IDLE;
        end else if (hold_expired) begin
          state_next = IDLE;
          rr_b_next  = 1'b0;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants are gated by reset so nothing reaches the memory while it is held
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          if (i_a_req && i_b_req) begin
            gnt_a = !rr_b;
            gnt_b = rr_b;
          end else begin
            gnt_a = i_a_req;
            gnt_b = i_b_req;
          end
        end
        OWN_A:   gnt_a = i_a_req;
        OWN_B:   gnt_b = i_b_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_mem_CS   = 1'b1;
    o_mem_WR   = 1'b0;
    o_mem_addr = '0;
    o_mem_data = '0;
    if (gnt_a) begin
      o_mem_CS   = 1'b0;
      o_mem_WR   = i_a_wr;
      o_mem_addr = i_a_addr;
      o_mem_data = i_a_wdata;
    end else if (gnt_b) begin
      o_mem_CS   = 1'b0;
      o_mem_WR   = i_b_wr;
      o_mem_addr = i_b_addr;
      o_mem_data = i_b_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= gnt_a & ~i_a_wr;
      b_rvalid <= gnt_b & ~i_b_wr;
    end
  end

  assign o_a_gnt    = gnt_a;
  assign o_b_gnt    = gnt_b;
  assign o_a_rvalid = a_rvalid;
  assign o_b_rvalid = b_rvalid;
  assign o_a_rdata  = a_rvalid ? i_mem_data : '0;
  assign o_b_rdata  = b_rvalid ? i_mem_data : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, memory address width (1024 words).
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter MAX_HOLD, default 32, maximum consecutive locked cycles for one owner.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have, per requester x in {a, b}, port i_x_req  input  1  access request this cycle.
REQ-007 SHALL have port i_x_lock  input  1  keep ownership for a burst after this grant.
REQ-008 SHALL have port i_x_wr  input  1  0 read, 1 write.
REQ-009 SHALL have port i_x_addr  input  AW  word address.
REQ-010 SHALL have port i_x_wdata  input  DW  write data.
REQ-011 SHALL have port o_x_gnt  output  1  access issued this cycle (combinational).
REQ-012 SHALL have port o_x_rvalid  output  1  read data valid.
REQ-013 SHALL have port o_x_rdata  output  DW  read data.
REQ-014 SHALL have port o_mem_CS  output  1  memory chip select, active low.
REQ-015 SHALL have port o_mem_WR  output  1  0 read, 1 write.
REQ-016 SHALL have port o_mem_addr  output  AW  memory address.
REQ-017 SHALL have port o_mem_data  output  DW  memory write data.
REQ-018 SHALL have port i_mem_data  input  DW  memory read data (registered in the memory, 1-cycle latency).

Function
REQ-019 SHALL implement an FSM with states IDLE, OWN_A, OWN_B.
REQ-020 In IDLE, SHALL grant at most one requester per cycle: the sole requester, or, if both request, the one not granted most recently (round-robin pointer).
REQ-021 In IDLE, a winner with i_x_lock=1 SHALL move the FSM to OWN_x on the next edge; the loser's lock SHALL be ignored.
REQ-022 In OWN_x, SHALL grant only x (whenever i_x_req=1); requests from the other requester SHALL wait with o_gnt=0.
REQ-023 In OWN_x, the FSM SHALL return to IDLE on the edge after a cycle with i_x_lock=0.
REQ-024 SHALL count consecutive OWN_x cycles; on reaching MAX_HOLD it SHALL force IDLE and point round-robin at the other requester.
REQ-025 SHALL update the round-robin pointer on every grant, to favour the non-granted requester.
REQ-026 With a grant, SHALL drive o_mem_CS=0 and pass the winner's wr/addr/wdata to the o_mem_* outputs in the same cycle.
REQ-027 With no grant, SHALL drive o_mem_CS=1, o_mem_WR=0, o_mem_addr=0, o_mem_data=0.
REQ-028 SHALL register o_x_rvalid as (o_x_gnt & ~i_x_wr) of the previous cycle.
REQ-029 o_x_rdata SHALL equal i_mem_data, qualified only by o_x_rvalid.
REQ-030 SHALL sustain one access per cycle back-to-back, including alternating requesters and read-after-write to the same address.
REQ-031 SHALL never assert o_a_gnt and o_b_gnt in the same cycle.

Reset
REQ-032 While i_rst=1, SHALL hold: FSM=IDLE, hold counter=0, pointer favouring a, o_x_rvalid=0, o_x_gnt=0, o_mem_CS=1, o_mem_WR=0, o_mem_addr=0, o_mem_data=0.
REQ-033 SHALL discard a reset asserted mid-burst or with a read outstanding: no rvalid is issued after reset release for pre-reset grants.

Structure
REQ-034 SHALL take AW, DW, memory depth 1024 and the FSM state enum from shared package dtw_mem_pkg.
REQ-035 SHALL be a single module; no sub-module.

Verification
REQ-036 Read: a reads addr 5, mem[5]=0x1234_5678 -> o_a_gnt same cycle, o_mem_CS=0; next cycle o_a_rvalid=1, o_a_rdata=0x1234_5678.
REQ-037 Contention: both request every cycle with no lock for 4 cycles after reset -> grants a,b,a,b.
REQ-038 Burst lock: a holds lock for 20 reads (addr 0..19) while b requests -> b has no grant until the cycle after a drops lock, then b granted.
REQ-039 Forced release: MAX_HOLD=4, a locks indefinitely, b requesting -> b granted within 6 cycles of a's first grant.
REQ-040 Write then read: b writes 0xDEAD_BEEF to addr 20, then reads addr 20 on the next cycle -> rvalid one cycle later with 0xDEAD_BEEF.
REQ-041 Reset mid-burst: i_rst pulsed during OWN_A with a read outstanding -> o_a_rvalid=0, o_mem_CS=1, FSM=IDLE after release.
